// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver FSM states, channel codes and the default
// sample width, which matches the DC-removal filter input width.
package i2s_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/i2s_rx_bit_sync.sv
// Multi-flop synchroniser for one asynchronous input bit. It also exposes the
// synchronised value from the previous clk so the caller can detect edges.
// Depth is clamped to at least two flops.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic prev_o
);

  localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

  logic [DEPTH-1:0] sync_q;
  logic             prev_q;

  // Shift the raw input through the flop chain and keep last cycle's output
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
      prev_q <= sync_q[DEPTH-1];
    end
  end

  assign q_o    = sync_q[DEPTH-1];
  assign prev_o = prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips format) slave receiver. SCK, WS and SD are synchronised into
// the clk domain, SCK rising edges are detected, and each slot is shifted in
// MSB first. A finished slot is left-justified into DATA_W bits, registered
// for one clk, and then written to out_l or out_r. out_valid fires when a
// right slot completes whose left slot of the same frame was also received,
// so a pulse always presents a matched stereo pair.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2s_sck,
  input  logic              i2s_ws,
  input  logic              i2s_sd,
  output logic [DATA_W-1:0] out_l,
  output logic [DATA_W-1:0] out_r,
  output logic              out_valid,
  output logic              short_slot
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

  // Synchronised inputs
  logic sck_s;
  logic sck_prev;
  logic ws_s;
  logic sd_s;
  logic ws_prev_unused;
  logic sd_prev_unused;

  logic sck_rise;
  logic ws_edge;

  // Slot capture state
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                chan_q, chan_d;
  logic                ws_prev_q, ws_prev_d;
  logic                pair_q, pair_d;

  // Bit count and shift contents including the bit of the current SCK edge
  logic [CNT_W-1:0]    slot_cnt;
  logic [DATA_W-1:0]   slot_word;

  // Completed-slot stage, one clk ahead of the outputs
  logic                done_q, done_d;
  logic                done_chan_q, done_chan_d;
  logic [DATA_W-1:0]   done_word_q, done_word_d;
  logic                done_short_q, done_short_d;
  logic                done_pair_q, done_pair_d;

  // Output registers
  logic [DATA_W-1:0]   out_l_q, out_l_d;
  logic [DATA_W-1:0]   out_r_q, out_r_d;
  logic                out_valid_q, out_valid_d;
  logic                short_slot_q, short_slot_d;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk    (clk),
    .rst    (rst),
    .d_i    (i2s_sck),
    .q_o    (sck_s),
    .prev_o (sck_prev)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_ws (
    .clk    (clk),
    .rst    (rst),
    .d_i    (i2s_ws),
    .q_o    (ws_s),
    .prev_o (ws_prev_unused)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_sd (
    .clk    (clk),
    .rst    (rst),
    .d_i    (i2s_sd),
    .q_o    (sd_s),
    .prev_o (sd_prev_unused)
  );

  assign sck_rise = sck_s & ~sck_prev;
  assign ws_edge  = (ws_s != ws_prev_q);

  // Register the slot capture state and the completed-slot stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      chan_q       <= CH_L;
      ws_prev_q    <= 1'b0;
      pair_q       <= 1'b0;
      done_q       <= 1'b0;
      done_chan_q  <= CH_L;
      done_word_q  <= '0;
      done_short_q <= 1'b0;
      done_pair_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      chan_q       <= chan_d;
      ws_prev_q    <= ws_prev_d;
      pair_q       <= pair_d;
      done_q       <= done_d;
      done_chan_q  <= done_chan_d;
      done_word_q  <= done_word_d;
      done_short_q <= done_short_d;
      done_pair_q  <= done_pair_d;
    end
  end

  // On each SCK rise: wait for the first WS edge, then shift bits until the
  // next WS edge closes the slot and hands a justified word to the done stage
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    chan_d       = chan_q;
    ws_prev_d    = ws_prev_q;
    pair_d       = pair_q;
    done_d       = 1'b0;
    done_chan_d  = done_chan_q;
    done_word_d  = done_word_q;
    done_short_d = 1'b0;
    done_pair_d  = done_pair_q;

    slot_cnt  = bit_cnt_q;
    slot_word = shreg_q;
    if (bit_cnt_q < CNT_MAX) begin
      slot_cnt  = bit_cnt_q + 1'b1;
      slot_word = {shreg_q[DATA_W-2:0], sd_s};
    end

    if (sck_rise) begin
      ws_prev_d = ws_s;
      case (state_q)
        IDLE: begin
          if (ws_edge) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            shreg_d   = '0;
            chan_d    = ws_s;
            pair_d    = 1'b0;
          end
        end
        SHIFT: begin
          if (ws_edge) begin
            done_d       = 1'b1;
            done_chan_d  = chan_q;
            done_word_d  = slot_word << (CNT_MAX - slot_cnt);
            done_short_d = (slot_cnt < CNT_MAX);
            done_pair_d  = pair_q;
            pair_d       = (chan_q == CH_L);
            bit_cnt_d    = '0;
            shreg_d      = '0;
            chan_d       = ws_s;
          end else begin
            bit_cnt_d = slot_cnt;
            shreg_d   = slot_word;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Register the output words and the single-clk status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      out_l_q      <= '0;
      out_r_q      <= '0;
      out_valid_q  <= 1'b0;
      short_slot_q <= 1'b0;
    end else begin
      out_l_q      <= out_l_d;
      out_r_q      <= out_r_d;
      out_valid_q  <= out_valid_d;
      short_slot_q <= short_slot_d;
    end
  end

  // Route a completed slot to its channel; a right word only publishes a frame
  // when the matching left word was captured just before it
  always_comb begin
    out_l_d      = out_l_q;
    out_r_d      = out_r_q;
    out_valid_d  = 1'b0;
    short_slot_d = done_q & done_short_q;
    if (done_q) begin
      if (done_chan_q == CH_L) begin
        out_l_d = done_word_q;
      end else if ((done_chan_q == CH_R) && done_pair_q) begin
        out_r_d     = done_word_q;
        out_valid_d = 1'b1;
      end
    end
  end

  assign out_l      = out_l_q;
  assign out_r      = out_r_q;
  assign out_valid  = out_valid_q;
  assign short_slot = short_slot_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Testbench for i2s_rx: drives an I2S serial stream into two receivers (two
// and three synchroniser stages) and compares every published frame against
// words computed directly from the transmitted sample values.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic        ws;
  logic        sd;

  logic [15:0] outL2, outR2, outL3, outR3;
  logic        valid2, short2, valid3, short3;

  int checks   = 0;
  int failures = 0;

  logic [15:0] expL[$];
  logic [15:0] expR[$];
  int          idx2, idx3, shortCnt2, shortCnt3;
  int          lat2, lat3;

  always #5 clk = ~clk;

  i2s_rx #(.DATA_W(16), .SYNC_STAGES(2), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .i2s_sck    (sck),
    .i2s_ws     (ws),
    .i2s_sd     (sd),
    .out_l      (outL2),
    .out_r      (outR2),
    .out_valid  (valid2),
    .short_slot (short2)
  );

  i2s_rx #(.DATA_W(16), .SYNC_STAGES(3), .CNT_W(6)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .i2s_sck    (sck),
    .i2s_ws     (ws),
    .i2s_sd     (sd),
    .out_l      (outL3),
    .out_r      (outR3),
    .out_valid  (valid3),
    .short_slot (short3)
  );

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Top 16 bits of an n-bit two's complement sample, zero filled when n < 16
  function automatic logic [15:0] justify(input logic [31:0] v, input int n);
    logic [63:0] w;
    w = 64'(v) & ((64'd1 << n) - 64'd1);
    if (n >= 16) return 16'(w >> (n - 16));
    else         return 16'(w << (16 - n));
  endfunction

  // Score every published frame and count short-slot pulses of both receivers
  always @(posedge clk) begin
    #1;
    if (valid2) begin
      if (idx2 < expL.size()) begin
        checkOutput("s2_out_l", 32'(outL2), 32'(expL[idx2]));
        checkOutput("s2_out_r", 32'(outR2), 32'(expR[idx2]));
      end
      idx2++;
    end
    if (valid3) begin
      if (idx3 < expL.size()) begin
        checkOutput("s3_out_l", 32'(outL3), 32'(expL[idx3]));
        checkOutput("s3_out_r", 32'(outR3), 32'(expR[idx3]));
      end
      idx3++;
    end
    if (short2) shortCnt2++;
    if (short3) shortCnt3++;
  end

  // One SCK period: WS/SD change while SCK is low, receivers sample on the rise
  task automatic applyStimulus(input logic wsBit, input logic sdBit);
    @(negedge clk);
    sck = 1'b0;
    ws  = wsBit;
    sd  = sdBit;
    repeat (3) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Bits [fromBit, toBit) of an n-bit slot; its LSB already carries the next WS
  task automatic sendSlot(input logic ch, input logic nextCh, input logic [31:0] v,
                          input int n, input int fromBit, input int toBit);
    for (int i = fromBit; i < toBit; i++)
      applyStimulus((i == n - 1) ? nextCh : ch, v[n-1-i]);
  endtask

  task automatic startTest();
    rst = 1'b1;
    sck = 1'b0;
    ws  = 1'b0;
    sd  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expL.delete();
    expR.delete();
    idx2 = 0;
    idx3 = 0;
    shortCnt2 = 0;
    shortCnt3 = 0;
  endtask

  task automatic runFrames(input int n, input int frames, input bit useRandom,
                           input logic [31:0] l0, input logic [31:0] r0,
                           input bit skipFirst);
    logic [31:0] l, r;
    for (int f = 0; f < frames; f++) begin
      l = useRandom ? $urandom : l0;
      r = useRandom ? $urandom : r0;
      if (!(skipFirst && f == 0)) begin
        expL.push_back(justify(l, n));
        expR.push_back(justify(r, n));
      end
      sendSlot(1'b0, 1'b1, l, n, 0, n);
      sendSlot(1'b1, 1'b0, r, n, 0, n);
    end
  endtask

  // Let the pipelines drain, then check frame and short-slot totals
  task automatic finishTest(input string name, input int expShort);
    @(negedge clk);
    sck = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput({name, "_frames_s2"}, 32'(idx2), 32'(expL.size()));
    checkOutput({name, "_frames_s3"}, 32'(idx3), 32'(expL.size()));
    if (expShort >= 0) begin
      checkOutput({name, "_short_s2"}, 32'(shortCnt2), 32'(expShort));
      checkOutput({name, "_short_s3"}, 32'(shortCnt3), 32'(expShort));
    end
  endtask

  initial begin
    int n;
    logic [31:0] l, r;

    // Reset state
    startTest();
    checkOutput("reset_out_l", 32'(outL2), 32'h0);
    checkOutput("reset_out_r", 32'(outR2), 32'h0);
    checkOutput("reset_valid", 32'(valid2), 32'h0);
    checkOutput("reset_short", 32'(short2), 32'h0);

    // Full 16-bit slots, first frame discarded
    runFrames(16, 4, 1'b0, 32'h1234, 32'hFEDC, 1'b1);
    finishTest("slot16", 0);

    // 24-bit slots: low bits dropped
    startTest();
    runFrames(24, 3, 1'b0, 32'h800001, 32'h7FFFFF, 1'b1);
    finishTest("slot24", 0);

    // 12-bit slots: zero filled, every completed slot is short
    startTest();
    runFrames(12, 3, 1'b0, 32'hABC, 32'h123, 1'b1);
    finishTest("slot12", 2 * 3 - 1);

    // Random slot widths and sample values
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 32);
      startTest();
      runFrames(n, 4, 1'b1, 32'h0, 32'h0, 1'b1);
      finishTest($sformatf("rand_w%0d", n), (n < 16) ? (2 * 4 - 1) : 0);
    end

    // Reset in the middle of a right slot
    startTest();
    runFrames(16, 2, 1'b1, 32'h0, 32'h0, 1'b1);
    l = $urandom;
    r = $urandom;
    sendSlot(1'b0, 1'b1, l, 16, 0, 16);
    sendSlot(1'b1, 1'b0, r, 16, 0, 8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_out_l_s2", 32'(outL2), 32'h0);
    checkOutput("midrst_out_r_s2", 32'(outR2), 32'h0);
    checkOutput("midrst_out_l_s3", 32'(outL3), 32'h0);
    checkOutput("midrst_out_r_s3", 32'(outR3), 32'h0);
    sendSlot(1'b1, 1'b0, r, 16, 8, 16);
    runFrames(16, 2, 1'b1, 32'h0, 32'h0, 1'b0);
    finishTest("midrst", -1);

    // Latency from the SCK rise carrying the right-slot LSB to out_valid
    startTest();
    runFrames(16, 1, 1'b1, 32'h0, 32'h0, 1'b1);
    l = $urandom;
    r = $urandom;
    expL.push_back(justify(l, 16));
    expR.push_back(justify(r, 16));
    sendSlot(1'b0, 1'b1, l, 16, 0, 16);
    sendSlot(1'b1, 1'b0, r, 16, 0, 15);
    @(negedge clk);
    sck = 1'b0;
    ws  = 1'b0;
    sd  = r[0];
    repeat (3) @(negedge clk);
    sck  = 1'b1;
    lat2 = 0;
    lat3 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (valid2 && lat2 == 0) lat2 = k;
      if (valid3 && lat3 == 0) lat3 = k;
    end
    checkOutput("latency_s2", 32'(lat2), 32'd4);
    checkOutput("latency_s3", 32'(lat3), 32'd5);
    finishTest("latency", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
